// File: rtl/bp_me_miss_arbiter_pkg.sv
// Shared types and helpers for the ME miss arbiter.
// Perf counter width lives here; the counters themselves are built only under BP_ME_MISS_ARB_PERF_EN.
package bp_me_miss_arbiter_pkg;

   localparam int unsigned PerfCntWidth = 32;

   typedef enum logic [0:0] {
      StIdle,
      StSend
   } arb_state_e;

   // ID width that stays at least 1 bit even for degenerate counts.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_me_miss_arbiter_if.sv
// Requester, ME command/response and perf signals of the miss arbiter.
// master is the arbiter's view; slave is the view of the surrounding requesters and ME.
interface bp_me_miss_arbiter_if #(
   parameter int unsigned num_req_p     = 2,
   parameter int unsigned paddr_width_p = 22,
   parameter int unsigned data_width_p  = 64
);
   import bp_me_miss_arbiter_pkg::*;

   logic [num_req_p-1:0]                   req_v_i;
   logic [num_req_p*paddr_width_p-1:0]     req_addr_i;
   logic [num_req_p-1:0]                   req_we_i;
   logic [num_req_p*data_width_p-1:0]      req_data_i;
   logic [num_req_p-1:0]                   req_ready_o;
   logic                                   mem_cmd_v_o;
   logic [paddr_width_p-1:0]               mem_cmd_addr_o;
   logic                                   mem_cmd_we_o;
   logic [data_width_p-1:0]                mem_cmd_data_o;
   logic                                   mem_cmd_ready_i;
   logic                                   mem_resp_v_i;
   logic [data_width_p-1:0]                mem_resp_data_i;
   logic                                   mem_resp_ready_o;
   logic [num_req_p-1:0]                   resp_v_o;
   logic [data_width_p-1:0]                resp_data_o;
   logic [num_req_p-1:0]                   resp_ready_i;
   logic [num_req_p*PerfCntWidth-1:0]      perf_grant_o;

   modport master (
      input  req_v_i, req_addr_i, req_we_i, req_data_i, mem_cmd_ready_i,
      input  mem_resp_v_i, mem_resp_data_i, resp_ready_i,
      output req_ready_o, mem_cmd_v_o, mem_cmd_addr_o, mem_cmd_we_o, mem_cmd_data_o,
      output mem_resp_ready_o, resp_v_o, resp_data_o, perf_grant_o
   );

   modport slave (
      output req_v_i, req_addr_i, req_we_i, req_data_i, mem_cmd_ready_i,
      output mem_resp_v_i, mem_resp_data_i, resp_ready_i,
      input  req_ready_o, mem_cmd_v_o, mem_cmd_addr_o, mem_cmd_we_o, mem_cmd_data_o,
      input  mem_resp_ready_o, resp_v_o, resp_data_o, perf_grant_o
   );

endinterface

// File: rtl/bp_me_arb_id_fifo.sv
// Circular queue of requester IDs for commands awaiting their in-order ME response.
// depth_p must be a power of 2 and at least 2; pointers carry an extra wrap bit.
module bp_me_arb_id_fifo #(
   parameter int unsigned width_p = 1,
   parameter int unsigned depth_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic               full_o,
   output logic               empty_o,
   output logic [width_p-1:0] head_o
);
   localparam int unsigned AddrWidth = $clog2(depth_p);
   localparam logic [AddrWidth:0] PtrOne = {{AddrWidth{1'b0}}, 1'b1};

   logic [AddrWidth:0] wptr_q, rptr_q;
   logic [width_p-1:0] mem_q [depth_p];
   logic               push_en, pop_en;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AddrWidth] != rptr_q[AddrWidth])
                 && (wptr_q[AddrWidth-1:0] == rptr_q[AddrWidth-1:0]);
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;
   assign head_o  = mem_q[rptr_q[AddrWidth-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_en) wptr_q <= wptr_q + PtrOne;
         if (pop_en)  rptr_q <= rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wptr_q[AddrWidth-1:0]] <= data_i;
   end

endmodule

// File: rtl/bp_me_miss_arbiter.sv
// Round-robin share of the ME command channel between cache-miss requesters, with in-order
// response routing by queued requester ID. BP_ME_MISS_ARB_PERF_EN adds per-requester grant counters.
module bp_me_miss_arbiter
   import bp_me_miss_arbiter_pkg::*;
#(
   parameter int unsigned num_req_p         = 2,
   parameter int unsigned paddr_width_p     = 22,
   parameter int unsigned data_width_p      = 64,
   parameter int unsigned max_outstanding_p = 4
) (
   input logic                  clk_i,
   input logic                  reset_i,
   bp_me_miss_arbiter_if.master bus
);
   localparam int unsigned IdWidth = safe_clog2(num_req_p);

   typedef struct packed {
      logic [paddr_width_p-1:0] addr;
      logic                     we;
      logic [data_width_p-1:0]  data;
   } bp_me_miss_cmd_s;

   arb_state_e      state_q, state_d;
   bp_me_miss_cmd_s cmd_q, cmd_d;
   logic [IdWidth-1:0] last_grant_q, last_grant_d;
   logic [IdWidth-1:0] winner;
   logic               found, can_accept, accept;
   logic               fifo_full, fifo_empty, fifo_pop;
   logic [IdWidth-1:0] fifo_head;
   logic [num_req_p-1:0] req_ready, resp_v;

   logic [num_req_p-1:0][paddr_width_p-1:0] req_addr;
   logic [num_req_p-1:0][data_width_p-1:0]  req_data;

   assign req_addr = bus.req_addr_i;
   assign req_data = bus.req_data_i;

   // Scan from the requester after the last grant, wrapping around.
   always_comb begin : arb_scan
      logic [IdWidth-1:0] cand;
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned off = 1; off <= num_req_p; off++) begin
         cand = IdWidth'((32'(last_grant_q) + off) % num_req_p);
         if (!found && bus.req_v_i[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      last_grant_d = last_grant_q;
      can_accept   = 1'b0;
      unique case (state_q)
         StIdle:  can_accept = !fifo_full;
         StSend:  can_accept = bus.mem_cmd_ready_i && !fifo_full;
         default: can_accept = 1'b0;
      endcase
      accept = can_accept && found;
      if (accept) begin
         cmd_d.addr   = req_addr[winner];
         cmd_d.we     = bus.req_we_i[winner];
         cmd_d.data   = req_data[winner];
         last_grant_d = winner;
         state_d      = StSend;
      end else if (state_q == StSend && bus.mem_cmd_ready_i) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         cmd_q        <= '0;
         last_grant_q <= IdWidth'(num_req_p - 1);
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         last_grant_q <= last_grant_d;
      end
   end

   bp_me_arb_id_fifo #(
      .width_p (IdWidth),
      .depth_p (max_outstanding_p)
   ) id_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (accept),
      .data_i  (winner),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   always_comb begin
      req_ready = '0;
      resp_v    = '0;
      if (accept) req_ready[winner] = 1'b1;
      if (bus.mem_resp_v_i && !fifo_empty) resp_v[fifo_head] = 1'b1;
   end

   assign bus.req_ready_o      = req_ready;
   assign bus.mem_cmd_v_o      = (state_q == StSend);
   assign bus.mem_cmd_addr_o   = cmd_q.addr;
   assign bus.mem_cmd_we_o     = cmd_q.we;
   assign bus.mem_cmd_data_o   = cmd_q.data;
   assign bus.resp_v_o         = resp_v;
   assign bus.resp_data_o      = bus.mem_resp_data_i;
   assign bus.mem_resp_ready_o = !fifo_empty && bus.resp_ready_i[fifo_head];
   assign fifo_pop             = bus.mem_resp_v_i && bus.mem_resp_ready_o;

`ifdef BP_ME_MISS_ARB_PERF_EN
   logic [num_req_p-1:0][PerfCntWidth-1:0] perf_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         perf_q <= '0;
      end else if (accept) begin
         perf_q[winner] <= perf_q[winner] + PerfCntWidth'(1);
      end
   end

   assign bus.perf_grant_o = perf_q;
`else
   assign bus.perf_grant_o = '0;
`endif

   // A response with nothing outstanding means the ME and this block disagree on ordering.
   assert property (@(posedge clk_i) disable iff (reset_i) !(bus.mem_resp_v_i && fifo_empty))
      else $error("mem_resp_v_i with no outstanding command");

endmodule
